// File: rtl/module_frame_rx_pkg.sv
// Shared types, frame layout and defaults for the frame receiver.
// Used by the receiver top, its link watchdog and the frame sender.
package module_frame_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    WAIT_LOW  = 2'd1,
    CHECK     = 2'd2
  } state_t;

  // byte 2 = {sin_index[3:0], uart_id}
  localparam int ID_MSB  = 3;
  localparam int IDX_LSB = 4;

  localparam logic [15:0] BYTE_TIMEOUT_DEF = 16'd2048;
  localparam logic [23:0] LINK_TIMEOUT_DEF = 24'd2400000;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/module_frame_rx_if.sv
// Byte bus from uart_rx into the frame receiver.
// master: uart_rx side drives; slave: receiver samples.
interface module_frame_rx_if;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;

  modport master (
    output data_received,
    output rx_done,
    output parity_error
  );

  modport slave (
    input data_received,
    input rx_done,
    input parity_error
  );
endinterface

// File: rtl/module_frame_rx_link.sv
// Link watchdog: saturating cycle counter cleared by kick.
// Ports: clk, reset, kick (frame accepted), link_lost (sticky level).
module module_frame_rx_link
  import module_frame_rx_pkg::*;
#(
  parameter logic [23:0] LINK_TIMEOUT = LINK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic kick,
  output logic link_lost
);

  logic [23:0] timer;

  // Link is considered lost out of reset until the first good frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer     <= '0;
      link_lost <= 1'b1;
    end else if (kick) begin
      timer     <= '0;
      link_lost <= 1'b0;
    end else if (timer != LINK_TIMEOUT) begin
      timer <= timer + 24'd1;
      if (timer + 24'd1 == LINK_TIMEOUT)
        link_lost <= 1'b1;
    end
  end

endmodule

// File: rtl/module_frame_rx.sv
// Two-byte frame receiver: assembles {sin_index, uart_id} from uart_rx.
// Ports: clk, reset, rx (byte bus), sin_index, uart_id, pulses, errors, link.
module module_frame_rx
  import module_frame_rx_pkg::*;
#(
  parameter logic [3:0]  MODULE_ID    = 4'h1,
  parameter logic [15:0] BYTE_TIMEOUT = BYTE_TIMEOUT_DEF,
  parameter logic [23:0] LINK_TIMEOUT = LINK_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  module_frame_rx_if.slave         rx,
  output logic [11:0]              sin_index,
  output logic [3:0]               uart_id,
  output logic                     frame_valid,
  output logic                     frame_error,
  output logic [7:0]               error_count,
  output logic                     link_lost
);

  state_t      state, state_n;
  logic [15:0] byte_timer, timer_n;
  logic [7:0]  hi_byte, lo_byte;
  logic        latch_hi, latch_lo;
  logic        accept, err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_HIGH;
      byte_timer  <= '0;
      hi_byte     <= '0;
      lo_byte     <= '0;
      sin_index   <= '0;
      uart_id     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      state       <= state_n;
      byte_timer  <= timer_n;
      frame_valid <= accept;
      frame_error <= err;
      if (latch_hi) hi_byte <= rx.data_received;
      if (latch_lo) lo_byte <= rx.data_received;
      if (err) error_count <= sat_inc(error_count);
      if (accept) begin
        sin_index <= {hi_byte, lo_byte[7:IDX_LSB]};
        uart_id   <= lo_byte[ID_MSB:0];
      end
    end
  end

  // CHECK also listens for byte 1 of the next frame so that a
  // back-to-back frame loses nothing.
  always_comb begin
    state_n  = state;
    timer_n  = byte_timer;
    latch_hi = 1'b0;
    latch_lo = 1'b0;
    accept   = 1'b0;
    err      = 1'b0;
    unique case (state)
      WAIT_HIGH, CHECK: begin
        accept  = (state == CHECK) &&
                  (lo_byte[ID_MSB:0] == MODULE_ID);
        state_n = WAIT_HIGH;
        if (rx.rx_done) begin
          if (rx.parity_error) begin
            err = 1'b1;
          end else begin
            latch_hi = 1'b1;
            timer_n  = '0;
            state_n  = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        // A byte in the expiry cycle wins over the timeout.
        if (rx.rx_done) begin
          if (rx.parity_error) begin
            err     = 1'b1;
            state_n = WAIT_HIGH;
          end else begin
            latch_lo = 1'b1;
            state_n  = CHECK;
          end
        end else if (byte_timer == BYTE_TIMEOUT - 16'd1) begin
          err     = 1'b1;
          state_n = WAIT_HIGH;
        end else begin
          timer_n = byte_timer + 16'd1;
        end
      end
      default: state_n = WAIT_HIGH;
    endcase
  end

  module_frame_rx_link #(
    .LINK_TIMEOUT (LINK_TIMEOUT)
  ) u_link (
    .clk       (clk),
    .reset     (reset),
    .kick      (accept),
    .link_lost (link_lost)
  );

endmodule

// File: tb/tb_module_frame_rx.sv
// Randomised bench for module_frame_rx against a cycle-stamped event model.
// No ports.
module tb_module_frame_rx;
  localparam logic [3:0] ID = 4'h1;
  localparam int BT = 128;
  localparam int LT = 600;
  localparam int N  = 32768;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sin_index;
  logic [3:0]  uart_id;
  logic        frame_valid, frame_error, link_lost;
  logic [7:0]  error_count;

  module_frame_rx_if rx_bus();

  module_frame_rx #(
    .MODULE_ID    (ID),
    .BYTE_TIMEOUT (16'(BT)),
    .LINK_TIMEOUT (24'(LT))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx_bus),
    .sin_index   (sin_index),
    .uart_id     (uart_id),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .error_count (error_count),
    .link_lost   (link_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected events per cycle, as seen on the outputs.
  int          e_fe [N];
  bit          e_fv [N];
  logic [15:0] e_idx[N];
  bit          e_rst[N];

  bit          pend = 0;
  logic [7:0]  hi = 0;
  int          hi_c = 0;

  function automatic bit ok(input int k);
    return k >= 0 && k < N;
  endfunction

  // Frame rules: byte 1 then byte 2 within BT cycles, else timeout
  // one cycle after the window closes; results show 1 (error) or
  // 2 (frame) cycles after the byte.
  task automatic model_byte(input int c, input logic [7:0] b,
                            input bit perr);
    if (pend && c > hi_c + BT) pend = 0;
    if (pend) begin
      if (ok(hi_c + BT + 1)) e_fe[hi_c + BT + 1]--;
      pend = 0;
      if (perr) begin
        if (ok(c + 1)) e_fe[c + 1]++;
      end else if (b[3:0] == ID && ok(c + 2)) begin
        e_fv[c + 2]  = 1;
        e_idx[c + 2] = {hi, b};
      end
    end else if (perr) begin
      if (ok(c + 1)) e_fe[c + 1]++;
    end else begin
      pend = 1;
      hi   = b;
      hi_c = c;
      if (ok(c + BT + 1)) e_fe[c + BT + 1]++;
    end
  endtask

  // Driver phase: always 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b, input bit perr);
    rx_bus.data_received = b;
    rx_bus.parity_error  = perr;
    rx_bus.rx_done       = 1'b1;
    model_byte(cyc, b, perr);
    @(posedge clk); #1;
    rx_bus.rx_done       = 1'b0;
    rx_bus.parity_error  = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pend = 0;
    for (int k = cyc; k < N; k++) begin
      e_fe[k] = 0;
      e_fv[k] = 0;
    end
    if (ok(cyc)) e_rst[cyc] = 1;
  endtask

  // Running expectation of the output registers.
  bit          en = 0;
  logic [11:0] m_sin = 0;
  logic [3:0]  m_id = 0;
  logic [7:0]  m_cnt = 0;
  int          m_last = -1;

  always @(negedge clk) begin
    if (en && ok(cyc)) begin
      if (e_rst[cyc]) begin
        m_sin = 0; m_id = 0; m_cnt = 0; m_last = -1;
      end
      if (e_fe[cyc] > 0 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (e_fv[cyc]) begin
        m_sin  = e_idx[cyc][15:4];
        m_id   = e_idx[cyc][3:0];
        m_last = cyc;
      end
      check("frame_valid", 32'(frame_valid), 32'(e_fv[cyc]));
      check("frame_error", 32'(frame_error), 32'(e_fe[cyc] > 0));
      check("sin_index", 32'(sin_index), 32'(m_sin));
      check("uart_id", 32'(uart_id), 32'(m_id));
      check("error_count", 32'(error_count), 32'(m_cnt));
      check("link_lost", 32'(link_lost),
            32'(m_last < 0 || cyc - m_last >= LT));
    end
  end

  initial begin
    rx_bus.data_received = 8'h00;
    rx_bus.rx_done       = 1'b0;
    rx_bus.parity_error  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    e_rst[cyc] = 1;
    en = 1;
    gap(2);

    // good frame, 100-cycle gap
    send(8'hAB, 0); gap(99); send(8'hC1, 0); gap(5);
    // id mismatch
    send(8'hAB, 0); send(8'hC5, 0); gap(5);
    // timeout then clean frame
    send(8'h12, 0); gap(BT + 3);
    send(8'h34, 0); send(8'h51, 0); gap(5);
    // byte exactly at the expiry cycle wins
    send(8'h56, 0); gap(BT - 1); send(8'h71, 0); gap(5);
    // one cycle too late: becomes byte 1
    send(8'h9A, 0); gap(BT); send(8'hBC, 0); send(8'hD1, 0); gap(3);
    // back-to-back frames through CHECK
    send(8'h11, 0); send(8'h21, 0); send(8'h33, 0); send(8'h41, 0);
    gap(3);
    // parity on byte 2
    send(8'hEE, 0); send(8'hF1, 1); gap(3);
    // link loss and recovery
    gap(LT + 5);
    send(8'h77, 0); send(8'h81, 0); gap(5);
    // reset mid-frame, then clean frame
    send(8'h55, 0); gap(2); do_reset(); gap(BT + 5);
    send(8'h66, 0); send(8'h71, 0); gap(3);
    // saturation
    for (int i = 0; i < 300; i++) send(8'(i), 1);
    gap(3);
    send(8'h42, 0); send(8'h31, 0); gap(3);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      int r, g;
      b = 8'($urandom);
      if ($urandom_range(1, 0) == 1) b[3:0] = ID;
      r = int'($urandom_range(99, 0));
      if (r < 70)      g = int'($urandom_range(3, 0));
      else if (r < 90) g = BT - 3 + int'($urandom_range(4, 0));
      else if (r < 97) g = int'($urandom_range(200, 0));
      else if (r < 99) g = LT + int'($urandom_range(20, 0));
      else             g = -1;
      if (g < 0) begin
        do_reset();
      end else begin
        gap(g);
        send(b, $urandom_range(7, 0) == 0);
      end
    end
    gap(BT + 10);
    en = 0;
    if (cyc >= N) check("cycle_budget", 32'(cyc), 32'(N - 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_frame_rx.md
MODULE_FRAME_RX -- requirements
Module: module_frame_rx

Interface
REQ-001 The block SHALL have parameter MODULE_ID, default 4'h1, meaning the 4-bit id this power module answers to.
REQ-002 The block SHALL have parameter BYTE_TIMEOUT, default 16'd2048, meaning the maximum clk cycles allowed between the first and second byte of a frame.
REQ-003 The block SHALL have parameter LINK_TIMEOUT, default 24'd2400000, meaning the clk cycles without a valid frame before the link is declared lost (100 ms at 24 MHz).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock (24 MHz HFOSC/2); reset  in  1  synchronous active-high reset.
REQ-005 Port: data_received  in  8  byte from uart_rx, valid when rx_done=1.
REQ-006 Port: rx_done  in  1  one-cycle strobe, new byte available.
REQ-007 Port: parity_error  in  1  qualifies the byte strobed by rx_done.
REQ-008 Port: sin_index  out  12  last accepted sine table index.
REQ-009 Port: uart_id  out  4  id field of the last accepted frame.
REQ-010 Port: frame_valid  out  1  one-cycle pulse, new frame accepted and id matched.
REQ-011 Port: frame_error  out  1  one-cycle pulse, frame discarded (parity or timeout).
REQ-012 Port: error_count  out  8  saturating count of discarded frames.
REQ-013 Port: link_lost  out  1  level, high while no valid frame arrived within LINK_TIMEOUT.

Function
REQ-014 A frame SHALL be two bytes: byte 1 = sin_index[11:4]; byte 2 = {sin_index[3:0], uart_id}.
REQ-015 The FSM SHALL have states WAIT_HIGH, WAIT_LOW, CHECK; reset state WAIT_HIGH.
REQ-016 WAIT_HIGH: on rx_done with parity_error=0, the block SHALL latch the byte as high nibble-pair, clear the byte timer and go to WAIT_LOW.
REQ-017 WAIT_HIGH: on rx_done with parity_error=1, the block SHALL drop the byte, pulse frame_error, and stay in WAIT_HIGH.
REQ-018 WAIT_LOW: the byte timer SHALL increment every cycle; on reaching BYTE_TIMEOUT without rx_done, the block SHALL pulse frame_error and return to WAIT_HIGH (resynchronisation).
REQ-019 WAIT_LOW: on rx_done with parity_error=1, the block SHALL pulse frame_error and return to WAIT_HIGH.
REQ-020 WAIT_LOW: on rx_done with parity_error=0, the block SHALL latch the byte and go to CHECK.
REQ-021 CHECK (one cycle): if byte2[3:0]==MODULE_ID, sin_index/uart_id SHALL update and frame_valid SHALL pulse in that same cycle; otherwise outputs hold, no pulse, no error; always return to WAIT_HIGH.
REQ-022 Latency: frame_valid SHALL assert exactly 2 cycles after the rx_done of byte 2.
REQ-023 rx_done coinciding with the BYTE_TIMEOUT expiry cycle SHALL be treated as byte 2 (byte wins over timeout).
REQ-024 rx_done arriving in CHECK SHALL be treated as byte 1 of the next frame (no byte lost).
REQ-025 error_count SHALL increment by 1 on every frame_error pulse and saturate at 8'hFF.
REQ-026 The link timer SHALL clear on every frame_valid and otherwise increment; link_lost SHALL be high when the timer reaches LINK_TIMEOUT and stay high until the next frame_valid, with the timer saturating.
REQ-027 sin_index and uart_id SHALL hold their values while link_lost is high.

Reset
REQ-028 On reset the block SHALL go to WAIT_HIGH, clear both timers, and drive sin_index=0, uart_id=0, frame_valid=0, frame_error=0, error_count=0, link_lost=1.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame without pulsing frame_error.

Structure
REQ-030 Frame layout field positions and the FSM state encodings SHALL be defined in the shared UART header (UART.vh) for use by the top-level sender.
REQ-031 Default timeout values SHALL be defined in config.vh alongside SEC_1/SEC_5.
REQ-032 The block SHALL instantiate no uart_rx; it is fed by one; the link watchdog SHALL reuse the existing timer module as its single sub-module, or be built as an inline counter.

Verification
REQ-033 Bytes 0xAB then 0xC1, gap 100 cycles, MODULE_ID=1 -> sin_index=0xABC, uart_id=1, frame_valid pulse 2 cycles after byte 2.
REQ-034 Bytes 0xAB, 0xC5 with MODULE_ID=1 -> no frame_valid, no frame_error, sin_index unchanged.
REQ-035 Byte 0x12 then no byte for BYTE_TIMEOUT cycles, then 0x34, 0x51 -> one frame_error, error_count=1, then sin_index=0x345.
REQ-036 Byte 2 with parity_error=1 -> frame_error pulse, state WAIT_HIGH, outputs unchanged; 300 errors -> error_count=0xFF.
REQ-037 After a valid frame, no traffic for LINK_TIMEOUT cycles -> link_lost=1; next valid frame -> link_lost=0 the same cycle frame_valid pulses.
REQ-038 Reset asserted between byte 1 and byte 2 -> no pulses, all outputs at reset values, next clean frame accepted.
